// File: rtl/led_pattern_ctrl_pkg.sv
// Shared encodings, seeds and the per-mode pattern step for the LED sequencer.
package led_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'd0,
    MODE_RING    = 2'd1,
    MODE_BINARY  = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_t;

  localparam logic [7:0] SEED_JOHNSON = 8'h00;
  localparam logic [7:0] SEED_RING    = 8'h01;
  localparam logic [7:0] SEED_BINARY  = 8'h00;

  // Settings captured on start from IDLE; run_len lives in the remaining counter.
  typedef struct packed {
    mode_t      mode;
    logic       dir;
    logic [1:0] rate_sel;
  } settings_t;

  function automatic logic [7:0] seed_for(input mode_t m, input logic [7:0] cur);
    case (m)
      MODE_JOHNSON: seed_for = SEED_JOHNSON;
      MODE_RING:    seed_for = SEED_RING;
      MODE_BINARY:  seed_for = SEED_BINARY;
      default:      seed_for = cur;
    endcase
  endfunction

  function automatic logic [7:0] advance_pattern(input mode_t m, input logic d,
                                                 input logic [7:0] v);
    case (m)
      MODE_JOHNSON: advance_pattern = d ? {~v[0], v[7:1]} : {v[6:0], ~v[7]};
      MODE_RING:    advance_pattern = d ? {v[0], v[7:1]} : {v[6:0], v[7]};
      MODE_BINARY:  advance_pattern = d ? v - 8'd1 : v + 8'd1;
      default:      advance_pattern = v;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_divider.sv
// Programmable tick divider: period is TICK_DIV >> shift cycles; holds its count while disabled.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] shift,
  output logic       tick_out
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] limit;

  assign limit    = CW'((TICK_DIV >> shift) - 32'd1);
  assign tick_out = enable && (cnt_reg == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= tick_out ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: IDLE/RUN/PAUSE control with Johnson, ring, binary and hold patterns.
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic       dir,
  input  logic [1:0] rate_sel,
  input  logic [7:0] run_len,
  output logic [7:0] q,
  output logic [1:0] state,
  output logic       tick,
  output logic       done
);

  state_t    state_reg, state_next;
  settings_t cfg_reg, cfg_next;
  logic [7:0] q_reg, q_next;
  logic [7:0] rem_reg, rem_next;
  logic       tick_reg, tick_next;
  logic       done_reg, done_next;
  logic       div_en, div_clear, div_tick;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk      (clk),
    .rst      (rst),
    .enable   (div_en),
    .clear    (div_clear),
    .shift    (cfg_reg.rate_sel),
    .tick_out (div_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cfg_reg   <= '0;
      q_reg     <= 8'h00;
      rem_reg   <= 8'h00;
      tick_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cfg_reg   <= cfg_next;
      q_reg     <= q_next;
      rem_reg   <= rem_next;
      tick_reg  <= tick_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cfg_next   = cfg_reg;
    q_next     = q_reg;
    rem_next   = rem_reg;
    tick_next  = 1'b0;
    done_next  = 1'b0;
    div_en     = 1'b0;
    div_clear  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!abort) begin
          if (start) begin
            cfg_next.mode     = mode_t'(mode);
            cfg_next.dir      = dir;
            cfg_next.rate_sel = rate_sel;
            rem_next          = run_len;
            q_next            = seed_for(mode_t'(mode), q_reg);
            div_clear         = 1'b1;
            state_next        = ST_RUN;
          end else if (step) begin
            q_next    = advance_pattern(mode_t'(mode), dir, q_reg);
            tick_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (stop) begin
          state_next = ST_PAUSE;
        end else begin
          div_en = 1'b1;
          if (div_tick) begin
            q_next    = advance_pattern(cfg_reg.mode, cfg_reg.dir, q_reg);
            tick_next = 1'b1;
            // A zero remaining count means continuous; finite runs end on reaching 1.
            if (rem_reg == 8'd1) begin
              rem_next   = 8'd0;
              done_next  = 1'b1;
              state_next = ST_IDLE;
            end else if (rem_reg != 8'd0) begin
              rem_next = rem_reg - 8'd1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (start) begin
          state_next = ST_RUN;
        end else if (step) begin
          q_next    = advance_pattern(cfg_reg.mode, cfg_reg.dir, q_reg);
          tick_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign q     = q_reg;
  assign state = state_reg;
  assign tick  = tick_reg;
  assign done  = done_reg;

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per pattern tick at rate_sel=0 (minimum 8).
REQ-002 clk  input  1  system clock, 50 MHz nominal.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse: begin or resume sequencing.
REQ-005 stop  input  1  single-cycle pulse: pause sequencing.
REQ-006 step  input  1  single-cycle pulse: advance exactly one pattern step.
REQ-007 abort  input  1  single-cycle pulse: return to IDLE.
REQ-008 mode  input  2  pattern: 0 Johnson, 1 ring, 2 binary, 3 hold.
REQ-009 dir  input  1  0 = shift-left / count up; 1 = shift-right / count down.
REQ-010 rate_sel  input  2  tick period = TICK_DIV >> rate_sel cycles.
REQ-011 run_len  input  8  ticks per run; 0 = continuous.
REQ-012 q  output  8  pattern value, registered.
REQ-013 state  output  2  0 IDLE, 1 RUN, 2 PAUSE.
REQ-014 tick  output  1  one-cycle pulse on every clk cycle in which q advances.
REQ-015 done  output  1  one-cycle pulse when a finite run completes.

Function
REQ-016 FSM states IDLE, RUN, PAUSE; an illegal encoding SHALL recover to IDLE on the next clk.
REQ-017 IDLE + start: latch mode, dir, rate_sel and run_len; load the seed (Johnson 8'h00, ring 8'h01, binary 8'h00, hold: q unchanged); clear the divider; enter RUN.
REQ-018 RUN + stop: enter PAUSE; q, divider and the remaining-tick count are frozen.
REQ-019 PAUSE + start: return to RUN with no reload; the divider resumes from its frozen value.
REQ-020 abort in any state: enter IDLE with q held, no tick, no done.
REQ-021 Priority for simultaneous pulses: abort > stop > start > step.
REQ-022 In RUN, a pattern advance SHALL occur when the divider reaches (TICK_DIV>>rate_sel)-1; the divider then wraps to 0 and tick asserts in the same cycle that q updates.
REQ-023 Johnson advance: dir 0 gives {q[6:0],~q[7]}; dir 1 gives {~q[0],q[7:1]}.
REQ-024 Ring advance: rotate left (dir 0) or rotate right (dir 1), 8 bits.
REQ-025 Binary advance: q+1 or q-1, modulo 256 (8'hFF+1 gives 8'h00; 8'h00-1 gives 8'hFF).
REQ-026 Hold advance: q unchanged, but tick still pulses.
REQ-027 step in IDLE or PAUSE: advance q once on the next clk using the latched settings (IDLE uses live inputs); tick pulses; state is unchanged; run_len is not decremented.
REQ-028 step in RUN SHALL be ignored.
REQ-029 A finite run (latched run_len=N, N>0): after the Nth tick, enter IDLE and pulse done in the same cycle as that Nth tick.
REQ-030 Live mode, dir, rate_sel and run_len changes during RUN or PAUSE SHALL be ignored until the next start from IDLE.
REQ-031 start in RUN SHALL be ignored; stop in IDLE or PAUSE SHALL be ignored.

Reset
REQ-032 rst SHALL force q=8'h00, state=IDLE, tick=0, done=0, divider=0 and remaining count=0 immediately, independent of clk.
REQ-033 rst asserted mid-run SHALL discard all latched settings; after deassertion the block waits for start.

Structure
REQ-034 A shared package SHALL hold the state encoding, the mode encoding and the seed constants.
REQ-035 The tick divider SHALL be one sub-module, tick_divider (enable, clear, shift, tick_out); the FSM and pattern datapath remain in the top level.

Verification (bench uses TICK_DIV=8)
REQ-036 start with mode=0, dir=0, rate_sel=0, run_len=0 -> tick every 8 cycles; q sequence 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,... repeats every 16 ticks.
REQ-037 mode=1, rate_sel=2, run_len=3 -> ticks every 2 cycles; q goes 01,02,04,08; done pulses with the third tick; state returns to IDLE.
REQ-038 mode=2, dir=1, step pulse from IDLE -> q goes 00 to FF; tick pulses once; state stays IDLE.
REQ-039 stop after 2 ticks, wait 50 cycles, then start -> no q change while paused; the next tick arrives exactly (8 - frozen divider value) cycles after resume.
REQ-040 start, stop and abort asserted together in RUN -> IDLE, no done; rst asserted mid-run -> q=00, state=IDLE within the same cycle.
